// File: rtl/multi_debouncer_if.sv
// multi_debouncer_if: raw input bank and debounced outputs / event pulses
// of multi_debouncer. The producer of x uses master; the debouncer uses slave.
interface multi_debouncer_if #(
    parameter int unsigned N = 4
);
    logic [N-1:0] x;
    logic [N-1:0] z;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] hold;
    logic         busy;

    modport master (output x, input z, rise, fall, hold, busy);
    modport slave  (input x, output z, rise, fall, hold, busy);
endinterface

// File: rtl/multi_debouncer.sv
// multi_debouncer: N-channel counter-based debouncer with per-channel
// rise/fall/hold event pulses and a global settling flag. All outputs are
// registered. Define MULTI_DEBOUNCER_SYNC_EN to place a 2-flop synchronizer
// per channel ahead of the counters (latency becomes DELAY+2 edges).
module multi_debouncer #(
    parameter int unsigned N         = 4,
    parameter int unsigned DELAY     = 5,
    parameter int unsigned HOLD      = 0,
    parameter bit          PULSE_POL = 1'b1,
    parameter bit          INIT      = 1'b0
) (
    input logic             ck,
    input logic             rst_n,
    multi_debouncer_if.slave bus
);
    localparam int unsigned   CW       = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DELAY - 1);

    logic [N-1:0]  xs;
    logic [N-1:0]  z_q;
    logic [N-1:0]  z_nx;
    logic [N-1:0]  rise_ev;
    logic [N-1:0]  fall_ev;
    logic [N-1:0]  hold_ev;
    logic [N-1:0]  rise_q;
    logic [N-1:0]  fall_q;
    logic [N-1:0]  hold_q;
    logic          busy_q;
    logic          busy_nx;
    logic [CW-1:0] cnt_q  [N];
    logic [CW-1:0] cnt_nx [N];

`ifdef MULTI_DEBOUNCER_SYNC_EN
    logic [N-1:0] sync1_q;
    logic [N-1:0] sync2_q;

    // Two-flop synchronizer per channel, reset to the idle level INIT
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= {N{INIT}};
            sync2_q <= {N{INIT}};
        end else begin
            sync1_q <= bus.x;
            sync2_q <= sync1_q;
        end
    end

    assign xs = sync2_q;
`else
    assign xs = bus.x;
`endif

    // Per-channel acceptance: count consecutive samples differing from z.
    // With DELAY=1 CNT_LAST is 0, so every differing sample is accepted and
    // the counter is constant zero (removed by synthesis).
    always_comb begin
        z_nx    = z_q;
        rise_ev = '0;
        fall_ev = '0;
        busy_nx = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            cnt_nx[i] = '0;
            if (xs[i] != z_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    z_nx[i]    = xs[i];
                    rise_ev[i] = xs[i];
                    fall_ev[i] = ~xs[i];
                end else begin
                    cnt_nx[i] = cnt_q[i] + 1'b1;
                end
            end
            busy_nx = busy_nx | (cnt_nx[i] != '0);
        end
    end

    generate
        if (HOLD > 0) begin : g_hold
            localparam int unsigned   HW       = $clog2(HOLD + 1);
            localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD);

            logic [HW-1:0] hcnt_q  [N];
            logic [HW-1:0] hcnt_nx [N];

            // High-time counter: cleared on any accepted edge, saturates at HOLD
            always_comb begin
                hold_ev = '0;
                for (int unsigned i = 0; i < N; i++) begin
                    hcnt_nx[i] = hcnt_q[i];
                    if (rise_ev[i] || fall_ev[i]) begin
                        hcnt_nx[i] = '0;
                    end else if (z_q[i] && (hcnt_q[i] != HOLD_MAX)) begin
                        hcnt_nx[i] = hcnt_q[i] + 1'b1;
                        hold_ev[i] = (hcnt_q[i] == HOLD_MAX - 1'b1);
                    end
                end
            end

            // A channel that resets high has no rise yet, so its counter
            // starts saturated and no hold pulse follows reset release.
            always_ff @(posedge ck or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < N; i++) begin
                        hcnt_q[i] <= INIT ? HOLD_MAX : '0;
                    end
                end else begin
                    for (int unsigned i = 0; i < N; i++) begin
                        hcnt_q[i] <= hcnt_nx[i];
                    end
                end
            end
        end else begin : g_no_hold
            // No hold logic at all when HOLD is zero
            always_comb begin
                hold_ev = '0;
            end
        end
    endgenerate

    // State and output registers; pulse polarity is applied before the flops
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            z_q    <= {N{INIT}};
            rise_q <= {N{~PULSE_POL}};
            fall_q <= {N{~PULSE_POL}};
            hold_q <= {N{~PULSE_POL}};
            busy_q <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            z_q    <= z_nx;
            rise_q <= rise_ev ^ {N{~PULSE_POL}};
            fall_q <= fall_ev ^ {N{~PULSE_POL}};
            hold_q <= hold_ev ^ {N{~PULSE_POL}};
            busy_q <= busy_nx;
            for (int unsigned i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_nx[i];
            end
        end
    end

    assign bus.z    = z_q;
    assign bus.rise = rise_q;
    assign bus.fall = fall_q;
    assign bus.hold = hold_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_multi_debouncer.sv
// tb_multi_debouncer: three multi_debouncer configurations (default,
// hold + active-low pulses + INIT=1, and DELAY=1/HOLD=1) checked against a
// run-length reference model, a stimulus table and hand-written sequences.
module tb_multi_debouncer;
    localparam int ND = 3;

    localparam int unsigned A_N = 4, A_DELAY = 5, A_HOLD = 0;
    localparam bit          A_POL = 1'b1, A_INIT = 1'b0;
    localparam int unsigned B_N = 4, B_DELAY = 2, B_HOLD = 10;
    localparam bit          B_POL = 1'b0, B_INIT = 1'b1;
    localparam int unsigned C_N = 2, C_DELAY = 1, C_HOLD = 1;
    localparam bit          C_POL = 1'b1, C_INIT = 1'b0;

`ifdef MULTI_DEBOUNCER_SYNC_EN
    localparam int SX = 2;
`else
    localparam int SX = 0;
`endif
    localparam int LAT_A = int'(A_DELAY) + SX;
    localparam int LAT_B = int'(B_DELAY) + SX;

    localparam int unsigned P_N     [ND] = '{A_N, B_N, C_N};
    localparam int unsigned P_DELAY [ND] = '{A_DELAY, B_DELAY, C_DELAY};
    localparam int unsigned P_HOLD  [ND] = '{A_HOLD, B_HOLD, C_HOLD};
    localparam bit          P_POL   [ND] = '{A_POL, B_POL, C_POL};
    localparam bit          P_INIT  [ND] = '{A_INIT, B_INIT, C_INIT};

    logic ck = 1'b0;
    logic rst_n;
    always #10 ck = ~ck;

    multi_debouncer_if #(.N(A_N)) ifa ();
    multi_debouncer_if #(.N(B_N)) ifb ();
    multi_debouncer_if #(.N(C_N)) ifc ();

    multi_debouncer #(.N(A_N), .DELAY(A_DELAY), .HOLD(A_HOLD), .PULSE_POL(A_POL), .INIT(A_INIT))
        dut_a (.ck(ck), .rst_n(rst_n), .bus(ifa));
    multi_debouncer #(.N(B_N), .DELAY(B_DELAY), .HOLD(B_HOLD), .PULSE_POL(B_POL), .INIT(B_INIT))
        dut_b (.ck(ck), .rst_n(rst_n), .bus(ifb));
    multi_debouncer #(.N(C_N), .DELAY(C_DELAY), .HOLD(C_HOLD), .PULSE_POL(C_POL), .INIT(C_INIT))
        dut_c (.ck(ck), .rst_n(rst_n), .bus(ifc));

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] xa, xb;
    logic [1:0] xc;

    // Reference model: z follows the input once the trailing run of identical
    // samples reaches DELAY with a value different from z.
    int   m_t;
    bit   m_z       [ND][4];
    bit   m_run_val [ND][4];
    int   m_run_len [ND][4];
    int   m_rise_t  [ND][4];
`ifdef MULTI_DEBOUNCER_SYNC_EN
    bit   m_s1 [ND][4];
    bit   m_s2 [ND][4];
`endif
    logic [3:0] e_z [ND], e_rise [ND], e_fall [ND], e_hold [ND];
    logic       e_busy [ND];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_t = 0;
        for (int d = 0; d < ND; d++) begin
            e_z[d] = '0; e_rise[d] = '0; e_fall[d] = '0; e_hold[d] = '0; e_busy[d] = 1'b0;
            for (int i = 0; i < int'(P_N[d]); i++) begin
                m_z[d][i]       = P_INIT[d];
                m_run_val[d][i] = P_INIT[d];
                m_run_len[d][i] = 0;
                m_rise_t[d][i]  = -1;
`ifdef MULTI_DEBOUNCER_SYNC_EN
                m_s1[d][i] = P_INIT[d];
                m_s2[d][i] = P_INIT[d];
`endif
                e_z[d][i] = P_INIT[d];
            end
        end
    endfunction

    function automatic void model_step(logic [3:0] ia, logic [3:0] ib, logic [3:0] ic);
        m_t++;
        for (int d = 0; d < ND; d++) begin
            logic [3:0] xin;
            xin = (d == 0) ? ia : (d == 1) ? ib : ic;
            e_rise[d] = '0; e_fall[d] = '0; e_hold[d] = '0; e_busy[d] = 1'b0;
            for (int i = 0; i < int'(P_N[d]); i++) begin
                bit xs;
`ifdef MULTI_DEBOUNCER_SYNC_EN
                xs = m_s2[d][i];
                m_s2[d][i] = m_s1[d][i];
                m_s1[d][i] = xin[i];
`else
                xs = xin[i];
`endif
                if (m_run_len[d][i] > 0 && xs == m_run_val[d][i]) begin
                    m_run_len[d][i]++;
                end else begin
                    m_run_val[d][i] = xs;
                    m_run_len[d][i] = 1;
                end
                if (m_run_val[d][i] != m_z[d][i] && m_run_len[d][i] >= int'(P_DELAY[d])) begin
                    m_z[d][i] = m_run_val[d][i];
                    if (m_z[d][i]) begin
                        e_rise[d][i] = 1'b1;
                        m_rise_t[d][i] = m_t;
                    end else begin
                        e_fall[d][i] = 1'b1;
                        m_rise_t[d][i] = -1;
                    end
                end
                if (P_HOLD[d] > 0 && m_z[d][i] && m_rise_t[d][i] >= 0 &&
                    (m_t - m_rise_t[d][i]) == int'(P_HOLD[d]))
                    e_hold[d][i] = 1'b1;
                if (m_run_len[d][i] > 0 && m_run_val[d][i] != m_z[d][i])
                    e_busy[d] = 1'b1;
                e_z[d][i] = m_z[d][i];
            end
        end
    endfunction

    function automatic logic [31:0] act_vec(int d);
        case (d)
            0:       return {15'b0, ifa.z, ifa.rise, ifa.fall, ifa.hold, ifa.busy};
            1:       return {15'b0, ifb.z, ifb.rise, ifb.fall, ifb.hold, ifb.busy};
            default: return {15'b0, 2'b0, ifc.z, 2'b0, ifc.rise, 2'b0, ifc.fall,
                             2'b0, ifc.hold, ifc.busy};
        endcase
    endfunction

    function automatic logic [31:0] exp_vec(int d);
        logic [3:0] mask, pm;
        mask = 4'((1 << P_N[d]) - 1);
        pm   = P_POL[d] ? 4'b0000 : mask;
        return {15'b0, e_z[d], e_rise[d] ^ pm, e_fall[d] ^ pm, e_hold[d] ^ pm, e_busy[d]};
    endfunction

    task automatic compare_all();
        for (int d = 0; d < ND; d++)
            check($sformatf("model_%0d", d), act_vec(d), exp_vec(d));
    endtask

    // One clock: drive current inputs, advance the model, sample #1 after the edge
    task automatic step();
        ifa.x = xa; ifb.x = xb; ifc.x = xc;
        @(posedge ck);
        model_step(xa, xb, {2'b00, xc});
        #1;
        compare_all();
    endtask

    typedef struct {
        logic [3:0] x;
        int         cycles;
        logic [3:0] z;
        int         rises;
        int         falls;
        logic       busy;
    } seg_t;
    seg_t tbl [8];

    int busy_seen, rise_cnt, rise_at, hold_at, n_hold, low_cnt, seen, pr, pf;
    logic [5:0] bounce;
    logic [3:0] la, lb;
    logic [1:0] lc;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{4'b0000, 12, 4'b0000, 0, 2, 1'b0};
        tbl[1] = '{4'b0001, 10, 4'b0001, 1, 0, 1'b0};
        tbl[2] = '{4'b0101,  4, 4'b0001, 0, 0, 1'b1};
        tbl[3] = '{4'b0001, 10, 4'b0001, 0, 0, 1'b0};
        tbl[4] = '{4'b1110, 12, 4'b1110, 3, 1, 1'b0};
        tbl[5] = '{4'b1010,  3, 4'b1110, 0, 0, 1'b1};
        tbl[6] = '{4'b1110, 10, 4'b1110, 0, 0, 1'b0};
        tbl[7] = '{4'b0000, 12, 4'b0000, 0, 3, 1'b0};

        xa = 4'b0000; xb = 4'b1111; xc = 2'b00;
        ifa.x = xa; ifb.x = xb; ifc.x = xc;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        repeat (3) @(posedge ck);
        #1;
        model_reset();
        compare_all();
        check("rst_a_outputs", {ifa.z, ifa.rise, ifa.fall, ifa.hold, ifa.busy}, 32'd0);
        check("rst_b_z", ifb.z, 32'hf);
        check("rst_b_pulses_idle", {ifb.rise, ifb.fall, ifb.hold, ifb.busy}, 32'h1ffe);
        @(negedge ck) rst_n = 1'b1;

        // Single press on A channel 0: accepted on the LAT_A-th edge, one rise
        xa = 4'b0001;
        for (int k = 1; k <= LAT_A + 2; k++) begin
            step();
            check("h1_z0", ifa.z[0], k >= LAT_A);
            check("h1_rise0", ifa.rise[0], k == LAT_A);
        end
        check("h1_others", ifa.z[3:1], 32'd0);

        // Bounce on A channel 1, then settle high
        bounce = 6'b011011;
        busy_seen = 0; rise_cnt = 0; rise_at = -1;
        for (int k = 0; k < 6 + LAT_A + 3; k++) begin
            xa[1] = (k < 6) ? bounce[k] : 1'b1;
            step();
            if (k < 6 && ifa.busy) busy_seen = 1;
            if (ifa.rise[1]) begin rise_cnt++; rise_at = k; end
        end
        check("h2_busy_bouncing", busy_seen, 1);
        check("h2_rise_count", rise_cnt, 1);
        check("h2_rise_time", rise_at, 5 + LAT_A);
        check("h2_busy_settled", ifa.busy, 0);

        // Table of segments on A
        for (int s = 0; s < 8; s++) begin
            xa = tbl[s].x; pr = 0; pf = 0;
            for (int k = 0; k < tbl[s].cycles; k++) begin
                step();
                pr += $countones(ifa.rise);
                pf += $countones(ifa.fall);
            end
            check($sformatf("tbl%0d_z", s), ifa.z, tbl[s].z);
            check($sformatf("tbl%0d_rises", s), pr, tbl[s].rises);
            check($sformatf("tbl%0d_falls", s), pf, tbl[s].falls);
            check($sformatf("tbl%0d_busy", s), ifa.busy, tbl[s].busy);
        end

        // B (active-low pulses, INIT=1): drop ch0 and ch3
        xb = 4'b0110; low_cnt = 0;
        for (int k = 0; k < LAT_B + 4; k++) begin
            step();
            if (!ifb.fall[0]) low_cnt++;
        end
        check("h3_fall0_pulses", low_cnt, 1);
        check("h3_z_after_drop", ifb.z, 32'h6);

        // Long press on B ch3: hold exactly HOLD edges after rise, once
        xb[3] = 1'b1; rise_at = -1; hold_at = -1; n_hold = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (!ifb.rise[3]) rise_at = k;
            if (!ifb.hold[3]) begin n_hold++; hold_at = k; end
        end
        check("h3_rise_time", rise_at, LAT_B - 1);
        check("h3_hold_count", n_hold, 1);
        check("h3_hold_delay", hold_at - rise_at, B_HOLD);

        // Short second press: released before HOLD, no hold pulse
        xb[3] = 1'b0;
        repeat (LAT_B + 4) step();
        xb[3] = 1'b1; n_hold = 0; seen = 0;
        for (int k = 0; k < LAT_B + 2 && seen == 0; k++) begin
            step();
            if (!ifb.rise[3]) seen = 1;
        end
        check("h3_second_rise", seen, 1);
        repeat (4) begin
            step();
            if (!ifb.hold[3]) n_hold++;
        end
        xb[3] = 1'b0;
        repeat (15) begin
            step();
            if (!ifb.hold[3]) n_hold++;
        end
        check("h3_no_hold_short", n_hold, 0);
        check("h3_z_final", ifb.z, 32'h6);

        // Asynchronous reset mid-count on A, then full latency again
        xa = 4'b0100;
        repeat (LAT_A + 2) step();
        xa = 4'b0101;
        repeat (3) step();
        check("pre_rst_busy", ifa.busy, 1);
        check("pre_rst_z", ifa.z, 32'h4);
        #4 rst_n = 1'b0;
        #2;
        model_reset();
        compare_all();
        check("mid_rst_a", {ifa.z, ifa.rise, ifa.fall, ifa.busy}, 32'd0);
        @(negedge ck) rst_n = 1'b1;
        rise_at = -1;
        for (int k = 0; k < LAT_A + 3; k++) begin
            step();
            if (ifa.rise[0]) rise_at = k;
        end
        check("post_rst_latency", rise_at, LAT_A - 1);

        // Randomized levels with occasional glitches, all configurations
        la = xa; lb = xb; lc = xc;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 15) == 0) la[i] = ~la[i];
                if ($urandom_range(0, 15) == 0) lb[i] = ~lb[i];
                xa[i] = la[i] ^ ($urandom_range(0, 9) == 0);
                xb[i] = lb[i] ^ ($urandom_range(0, 9) == 0);
            end
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 7) == 0) lc[i] = ~lc[i];
                xc[i] = lc[i] ^ ($urandom_range(0, 9) == 0);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
